// File: rtl/ex_operand_stage_pkg.sv
// Shared opcode/funct encodings and ALU operation codes for the EX stage and ALU.
// Also holds the instruction decoder that produces the registered aluop.
package ex_operand_stage_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  localparam logic [3:0] ALUOP_AND = 4'b0000;
  localparam logic [3:0] ALUOP_OR  = 4'b0001;
  localparam logic [3:0] ALUOP_ADD = 4'b0010;
  localparam logic [3:0] ALUOP_SUB = 4'b0110;
  localparam logic [3:0] ALUOP_SLT = 4'b0111;
  localparam logic [3:0] ALUOP_NOR = 4'b1100;

  typedef struct packed {
    logic [3:0] aluop;
    logic       known;   // 0 turns the instruction into a bubble
    logic       rw_ok;   // 0 suppresses the register write
    logic       b_imm;   // operand b comes from the immediate
  } dec_t;

  function automatic dec_t decode(input logic [5:0] opcode, input logic [5:0] funct);
    dec_t d;
    d.aluop = ALUOP_ADD;
    d.known = 1'b1;
    d.rw_ok = 1'b1;
    d.b_imm = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        d.b_imm = 1'b0;
        case (funct)
          FN_ADD, FN_ADDU: d.aluop = ALUOP_ADD;
          FN_SUB, FN_SUBU: d.aluop = ALUOP_SUB;
          FN_AND:          d.aluop = ALUOP_AND;
          FN_OR:           d.aluop = ALUOP_OR;
          FN_NOR:          d.aluop = ALUOP_NOR;
          FN_SLT:          d.aluop = ALUOP_SLT;
          default:         d.rw_ok = 1'b0;
        endcase
      end
      OP_LW, OP_SW, OP_ADDI, OP_ADDIU: d.aluop = ALUOP_ADD;
      OP_BEQ: begin
        d.aluop = ALUOP_SUB;
        d.b_imm = 1'b0;
      end
      OP_ANDI: d.aluop = ALUOP_AND;
      OP_ORI:  d.aluop = ALUOP_OR;
      OP_SLTI: d.aluop = ALUOP_SLT;
      default: d.known = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/ex_operand_stage_fwd_mux.sv
// Forwarding select for one ALU source operand: EX/MEM beats MEM/WB beats register file.
// Register 0 is hard-wired zero and is never forwarded.
module ex_operand_stage_fwd_mux #(
  parameter int XLEN  = 32,
  parameter int RADDR = 5
) (
  input  logic [RADDR-1:0] i_src,
  input  logic [XLEN-1:0]  i_rf_data,
  input  logic             i_exmem_regwrite,
  input  logic [RADDR-1:0] i_exmem_rd,
  input  logic [XLEN-1:0]  i_exmem_result,
  input  logic             i_memwb_regwrite,
  input  logic [RADDR-1:0] i_memwb_rd,
  input  logic [XLEN-1:0]  i_memwb_result,
  output logic [XLEN-1:0]  o_data
);

  logic w_hit_exmem;
  logic w_hit_memwb;

  assign w_hit_exmem = i_exmem_regwrite && (i_exmem_rd != '0) && (i_exmem_rd == i_src);
  assign w_hit_memwb = i_memwb_regwrite && (i_memwb_rd != '0) && (i_memwb_rd == i_src);

  always_comb begin
    o_data = i_rf_data;
    if (w_hit_exmem)      o_data = i_exmem_result;
    else if (w_hit_memwb) o_data = i_memwb_result;
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with aluop decode, operand forwarding and load-use stall detection.
// Feeds the single-cycle 32-bit ALU, so the EX stage itself never holds.
module ex_operand_stage
  import ex_operand_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int RADDR = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [5:0]       id_opcode,
  input  logic [5:0]       id_funct,
  input  logic [RADDR-1:0] id_rs,
  input  logic [RADDR-1:0] id_rt,
  input  logic [RADDR-1:0] id_rd,
  input  logic [XLEN-1:0]  id_rs_data,
  input  logic [XLEN-1:0]  id_rt_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             id_memwrite,
  input  logic             id_memtoreg,
  input  logic             flush,
  input  logic             exmem_regwrite,
  input  logic [RADDR-1:0] exmem_rd,
  input  logic [XLEN-1:0]  exmem_result,
  input  logic             memwb_regwrite,
  input  logic [RADDR-1:0] memwb_rd,
  input  logic [XLEN-1:0]  memwb_result,
  output logic             stall_req,
  output logic [XLEN-1:0]  alu_a,
  output logic [XLEN-1:0]  alu_b,
  output logic [3:0]       aluop,
  output logic [XLEN-1:0]  ex_store_data,
  output logic [RADDR-1:0] ex_rd,
  output logic             ex_valid,
  output logic             ex_regwrite,
  output logic             ex_memread,
  output logic             ex_memwrite,
  output logic             ex_memtoreg
);

  logic             r_valid;
  logic             r_regwrite;
  logic             r_memread;
  logic             r_memwrite;
  logic             r_memtoreg;
  logic [3:0]       r_aluop;
  logic             r_b_imm;
  logic [RADDR-1:0] r_rs;
  logic [RADDR-1:0] r_rt;
  logic [RADDR-1:0] r_rd;
  logic [XLEN-1:0]  r_rs_data;
  logic [XLEN-1:0]  r_rt_data;
  logic [XLEN-1:0]  r_imm;

  dec_t             w_dec;
  logic             w_bubble;
  logic             w_take;
  logic [XLEN-1:0]  w_fwd_rs;
  logic [XLEN-1:0]  w_fwd_rt;

  assign w_dec = decode(id_opcode, id_funct);

  // A load in EX cannot forward its data yet, so a dependent instruction waits one cycle in ID.
  assign stall_req = id_valid && r_valid && r_memread && (r_rd != '0) &&
                     ((r_rd == id_rs) || (r_rd == id_rt));
  assign w_bubble  = stall_req || flush;
  assign w_take    = id_valid && w_dec.known;

  // ID -> EX boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
      r_memtoreg <= 1'b0;
      r_aluop    <= ALUOP_AND;
      r_b_imm    <= 1'b0;
      r_rs       <= '0;
      r_rt       <= '0;
      r_rd       <= '0;
      r_rs_data  <= '0;
      r_rt_data  <= '0;
      r_imm      <= '0;
    end else if (w_bubble) begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
      r_memtoreg <= 1'b0;
    end else begin
      r_valid    <= w_take;
      r_regwrite <= w_take && w_dec.rw_ok && id_regwrite;
      r_memread  <= w_take && id_memread;
      r_memwrite <= w_take && id_memwrite;
      r_memtoreg <= w_take && id_memtoreg;
      r_aluop    <= w_dec.aluop;
      r_b_imm    <= w_dec.b_imm;
      r_rs       <= id_rs;
      r_rt       <= id_rt;
      r_rd       <= id_rd;
      r_rs_data  <= id_rs_data;
      r_rt_data  <= id_rt_data;
      r_imm      <= id_imm;
    end
  end

  ex_operand_stage_fwd_mux #(.XLEN(XLEN), .RADDR(RADDR)) u_fwd_rs (
    .i_src            (r_rs),
    .i_rf_data        (r_rs_data),
    .i_exmem_regwrite (exmem_regwrite),
    .i_exmem_rd       (exmem_rd),
    .i_exmem_result   (exmem_result),
    .i_memwb_regwrite (memwb_regwrite),
    .i_memwb_rd       (memwb_rd),
    .i_memwb_result   (memwb_result),
    .o_data           (w_fwd_rs)
  );

  ex_operand_stage_fwd_mux #(.XLEN(XLEN), .RADDR(RADDR)) u_fwd_rt (
    .i_src            (r_rt),
    .i_rf_data        (r_rt_data),
    .i_exmem_regwrite (exmem_regwrite),
    .i_exmem_rd       (exmem_rd),
    .i_exmem_result   (exmem_result),
    .i_memwb_regwrite (memwb_regwrite),
    .i_memwb_rd       (memwb_rd),
    .i_memwb_result   (memwb_result),
    .o_data           (w_fwd_rt)
  );

  assign alu_a         = w_fwd_rs;
  assign alu_b         = r_b_imm ? r_imm : w_fwd_rt;
  assign ex_store_data = w_fwd_rt;
  assign aluop         = r_aluop;
  assign ex_rd         = r_rd;
  assign ex_valid      = r_valid;
  assign ex_regwrite   = r_regwrite;
  assign ex_memread    = r_memread;
  assign ex_memwrite   = r_memwrite;
  assign ex_memtoreg   = r_memtoreg;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: decode, forwarding priority, load-use stall, flush, reset.
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [5:0]  id_opcode, id_funct;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic        id_regwrite, id_memread, id_memwrite, id_memtoreg;
  logic        flush;
  logic        exmem_regwrite, memwb_regwrite;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic        stall_req;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [3:0]  aluop;
  logic [4:0]  ex_rd;
  logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ex_operand_stage #(.XLEN(32), .RADDR(5)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode), .id_funct(id_funct),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .id_memtoreg(id_memtoreg), .flush(flush), .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd),
    .exmem_result(exmem_result), .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd),
    .memwb_result(memwb_result), .stall_req(stall_req), .alu_a(alu_a), .alu_b(alu_b), .aluop(aluop),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_valid(ex_valid), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] rsd,
                        input logic [31:0] rtd, input logic [31:0] imm, input logic rw,
                        input logic mr, input logic mw, input logic mtr);
    id_valid = 1'b1; id_opcode = op; id_funct = fn; id_rs = rs; id_rt = rt; id_rd = rd;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
    id_regwrite = rw; id_memread = mr; id_memwrite = mw; id_memtoreg = mtr;
  endtask

  task automatic clr_fwd();
    exmem_regwrite = 1'b0; exmem_rd = '0; exmem_result = '0;
    memwb_regwrite = 1'b0; memwb_rd = '0; memwb_result = '0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    set_id(6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    id_valid = 1'b0;
    clr_fwd();
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_valid", ex_valid, 0);
    chk("rst_aluop", aluop, 4'b0000);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_rd", ex_rd, 0);
    chk("rst_stall", stall_req, 0);

    // sub $3,$1,$2
    set_id(6'h00, 6'h22, 5'd1, 5'd2, 5'd3, 32'd7, 32'd5, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("sub_aluop", aluop, 4'b0110);
    chk("sub_a", alu_a, 7);
    chk("sub_b", alu_b, 5);
    chk("sub_rd", ex_rd, 3);
    chk("sub_rw", ex_regwrite, 1);
    chk("sub_valid", ex_valid, 1);

    // add $4,$1,$2 with both later stages writing $1
    set_id(6'h00, 6'h20, 5'd1, 5'd2, 5'd4, 32'h11, 32'h22, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    exmem_regwrite = 1'b1; exmem_rd = 5'd1; exmem_result = 32'h100;
    memwb_regwrite = 1'b1; memwb_rd = 5'd1; memwb_result = 32'h200;
    tick();
    id_valid = 1'b0;
    chk("dbl_exmem_a", alu_a, 32'h100);
    chk("dbl_aluop", aluop, 4'b0010);
    chk("dbl_b_rf", alu_b, 32'h22);
    exmem_regwrite = 1'b0; #1;
    chk("dbl_memwb_a", alu_a, 32'h200);
    exmem_regwrite = 1'b1; exmem_rd = 5'd0; memwb_rd = 5'd0; #1;
    chk("dbl_rd0_a", alu_a, 32'h11);
    memwb_rd = 5'd2; #1;
    chk("rt_memwb_b", alu_b, 32'h200);
    chk("rt_memwb_a", alu_a, 32'h11);
    clr_fwd();

    // Asynchronous reset mid-cycle while EX holds a valid instruction
    chk("pre_rst_valid", ex_valid, 1);
    rst = 1'b1; #1;
    chk("async_rst_valid", ex_valid, 0);
    chk("async_rst_aluop", aluop, 4'b0000);
    chk("async_rst_rw", ex_regwrite, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_valid", ex_valid, 0);

    // Register 0 is never forwarded: add $5,$0,$0 with EX/MEM claiming $0
    set_id(6'h00, 6'h20, 5'd0, 5'd0, 5'd5, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    exmem_regwrite = 1'b1; exmem_rd = 5'd0; exmem_result = 32'h777;
    tick();
    chk("r0_no_fwd", alu_a, 0);
    clr_fwd();

    // Load-use: lw $4,8($6) then add $5,$4,$7
    set_id(6'h23, 6'h00, 5'd6, 5'd4, 5'd4, 32'h40, 32'h0, 32'd8, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    chk("lw_memread", ex_memread, 1);
    chk("lw_a", alu_a, 32'h40);
    chk("lw_b", alu_b, 8);
    id_valid = 1'b0; #1;
    chk("stall_gated_idvalid", stall_req, 0);
    set_id(6'h00, 6'h20, 5'd4, 5'd7, 5'd5, 32'h99, 32'd3, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("loaduse_stall", stall_req, 1);
    tick();
    chk("bubble_valid", ex_valid, 0);
    chk("bubble_rw", ex_regwrite, 0);
    chk("bubble_mr", ex_memread, 0);
    chk("bubble_mw", ex_memwrite, 0);
    chk("bubble_mtr", ex_memtoreg, 0);
    chk("bubble_nostall", stall_req, 0);
    exmem_regwrite = 1'b1; exmem_rd = 5'd4; exmem_result = 32'h48;
    tick();
    id_valid = 1'b0;
    exmem_regwrite = 1'b0; exmem_rd = 5'd0;
    memwb_regwrite = 1'b1; memwb_rd = 5'd4; memwb_result = 32'h1234;
    #1;
    chk("lu_add_valid", ex_valid, 1);
    chk("lu_add_a", alu_a, 32'h1234);
    chk("lu_add_b", alu_b, 3);
    clr_fwd();

    // sw $5,-4($6) with $5 forwarded from EX/MEM
    set_id(6'h2B, 6'h00, 5'd6, 5'd5, 5'd0, 32'h1000, 32'h55, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b1, 1'b0);
    exmem_regwrite = 1'b1; exmem_rd = 5'd5; exmem_result = 32'hDEAD;
    tick();
    chk("sw_b_imm", alu_b, 32'hFFFF_FFFC);
    chk("sw_store", ex_store_data, 32'hDEAD);
    chk("sw_aluop", aluop, 4'b0010);
    chk("sw_mw", ex_memwrite, 1);
    chk("sw_a", alu_a, 32'h1000);
    chk("sw_rw", ex_regwrite, 0);
    clr_fwd();

    // Flush squashes ori; then the same ori issues normally
    set_id(6'h0D, 6'h00, 5'd1, 5'd2, 5'd2, 32'h30, 32'h0, 32'hF, 1'b1, 1'b0, 1'b0, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_rw", ex_regwrite, 0);
    chk("flush_valid", ex_valid, 0);
    tick();
    chk("ori_aluop", aluop, 4'b0001);
    chk("ori_rw", ex_regwrite, 1);
    chk("ori_b", alu_b, 32'hF);

    // Remaining decode entries
    set_id(6'h00, 6'h2A, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("slt_aluop", aluop, 4'b0111);
    set_id(6'h00, 6'h27, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("nor_aluop", aluop, 4'b1100);
    set_id(6'h00, 6'h24, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("and_aluop", aluop, 4'b0000);
    set_id(6'h00, 6'h00, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("badfn_aluop", aluop, 4'b0010);
    chk("badfn_rw", ex_regwrite, 0);
    chk("badfn_valid", ex_valid, 1);
    set_id(6'h04, 6'h00, 5'd1, 5'd2, 5'd0, 32'h9, 32'h6, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("beq_aluop", aluop, 4'b0110);
    chk("beq_b_rt", alu_b, 32'h6);
    set_id(6'h0A, 6'h00, 5'd1, 5'd2, 5'd2, 32'h9, 32'h6, 32'h40, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("slti_aluop", aluop, 4'b0111);
    chk("slti_b_imm", alu_b, 32'h40);

    // Unknown opcode becomes a bubble
    set_id(6'h3F, 6'h00, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    chk("badop_rw", ex_regwrite, 0);
    chk("badop_mw", ex_memwrite, 0);
    chk("badop_valid", ex_valid, 0);

    // id_valid=0 gates control bits
    set_id(6'h08, 6'h00, 5'd1, 5'd2, 5'd2, 32'h1, 32'h2, 32'h5, 1'b1, 1'b0, 1'b0, 1'b0);
    id_valid = 1'b0;
    tick();
    chk("novalid_rw", ex_regwrite, 0);
    chk("novalid_valid", ex_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed no finish, expected finish before 20000");
    $fatal(1);
  end

endmodule
